// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out word serializer.
// A frame of MEMORY_WID words is captured through a valid/ready load port.
// It is replayed one word per beat, word 0 first, on a valid/ready serial port.
// If a new frame is offered during the last beat, it is captured in that same
// beat, so consecutive frames go out back to back with no idle cycle.
module piso_serializer #(
    parameter int DATA_WID   = 8,
    parameter int MEMORY_WID = 4,
    parameter int CNT_WID    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WID*MEMORY_WID-1:0] load_data,
    input  logic                           load_valid,
    output logic                           load_ready,
    output logic [DATA_WID-1:0]            ser_data,
    output logic                           ser_valid,
    input  logic                           ser_ready,
    output logic                           ser_first,
    output logic                           ser_last,
    output logic                           busy,
    output logic [CNT_WID-1:0]             frame_cnt
);

    localparam int IDX_WID = (MEMORY_WID > 1) ? $clog2(MEMORY_WID) : 1;
    localparam logic [IDX_WID-1:0] LAST_IDX = IDX_WID'(MEMORY_WID - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state;
    logic [IDX_WID-1:0]   word_idx;
    logic [DATA_WID-1:0]  shadow [MEMORY_WID];
    logic                 last_xfer;
    logic                 load_accept;

    // A frame can be taken when idle, or when the final word leaves this cycle.
    // NOTE: load_ready depends combinationally on ser_ready so that a new frame
    // can be taken during the final beat; every ser_* output stays registered.
    assign last_xfer   = (state == SHIFT) && ser_last && ser_ready;
    assign load_ready  = (state == IDLE) || last_xfer;
    assign load_accept = load_valid && load_ready;

    // Serial side is decoded straight from registers: state and the word mux.
    assign ser_valid = (state == SHIFT);
    assign busy      = (state == SHIFT);
    assign ser_data  = (state == SHIFT) ? shadow[word_idx] : '0;

    // Frame FSM: capture, advance word index on each beat, count finished frames.
    always_ff @(posedge clk) begin
        // NOTE: all state is updated with non-blocking assignments so every
        // register samples the values from before this edge, in any order.
        if (!rst_n) begin
            state     <= IDLE;
            word_idx  <= '0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
            frame_cnt <= '0;
            // NOTE: the shadow words are reset as well, so ser_data comes out
            // of reset as a known 0 and never shows stale frame contents.
            for (int i = 0; i < MEMORY_WID; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            if (load_accept) begin
                for (int i = 0; i < MEMORY_WID; i++) begin
                    shadow[i] <= load_data[i*DATA_WID +: DATA_WID];
                end
                state     <= SHIFT;
                word_idx  <= '0;
                ser_first <= 1'b1;
                ser_last  <= (LAST_IDX == '0);
            end else if ((state == SHIFT) && ser_ready) begin
                if (ser_last) begin
                    state     <= IDLE;
                    ser_first <= 1'b0;
                    ser_last  <= 1'b0;
                end else begin
                    word_idx  <= word_idx + IDX_WID'(1);
                    ser_first <= 1'b0;
                    ser_last  <= ((word_idx + IDX_WID'(1)) == LAST_IDX);
                end
            end

            if (last_xfer) begin
                frame_cnt <= frame_cnt + CNT_WID'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (4 words x 8 bits, 2-bit frame counter).
// Directed vectors cover the single-frame, stall, back-to-back and load-while-busy
// cases.  A hand-written sequence covers reset in the middle of a frame.
// The random phase is checked against a queue-based reference model.
module tb_piso_serializer;

    localparam int DW = 8;
    localparam int MW = 4;
    localparam int CW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DW*MW-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic [DW-1:0]    ser_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_first;
    logic             ser_last;
    logic             busy;
    logic [CW-1:0]    frame_cnt;

    int total  = 0;
    int passed = 0;

    piso_serializer #(.DATA_WID(DW), .MEMORY_WID(MW), .CNT_WID(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_data   (ser_data),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_first  (ser_first),
        .ser_last   (ser_last),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          lv;
        logic [31:0]   ld;
        logic          sr;
        logic          ev;
        logic [7:0]    ed;
        logic          ef;
        logic          el;
        logic          er;
        logic [CW-1:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic lv, logic [31:0] ld, logic sr, logic ev,
                                logic [7:0] ed, logic ef, logic el, logic er,
                                logic [CW-1:0] ec);
        vec_t v;
        v.lv = lv; v.ld = ld; v.sr = sr; v.ev = ev; v.ed = ed;
        v.ef = ef; v.el = el; v.er = er; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Compare every observable output against one set of expectations.
    task automatic cmp(input string tag, input logic ev, input logic [7:0] ed,
                       input logic ef, input logic el, input logic er,
                       input logic [CW-1:0] ec);
        check({tag, ".ser_valid"}, 32'(ser_valid), 32'(ev));
        check({tag, ".busy"}, 32'(busy), 32'(ev));
        check({tag, ".load_ready"}, 32'(load_ready), 32'(er));
        check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(ec));
        if (ev) begin
            check({tag, ".ser_data"}, 32'(ser_data), 32'(ed));
            check({tag, ".ser_first"}, 32'(ser_first), 32'(ef));
            check({tag, ".ser_last"}, 32'(ser_last), 32'(el));
        end
    endtask

    localparam logic [31:0] FA = 32'h4433_2211;
    localparam logic [31:0] FB = 32'h8877_6655;
    localparam logic [31:0] FC = 32'hDEAD_BEEF;

    // Reference model state: words of the current frame not yet sent, frames sent.
    logic [7:0] exp_q[$];
    int         sent_frames;

    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; ser_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.ser_data", 32'(ser_data), 32'h0);
        check("reset.ser_first", 32'(ser_first), 32'h0);
        check("reset.ser_last", 32'(ser_last), 32'h0);
        cmp("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0);
        rst_n = 1'b1;

        // single frame
        tbl.push_back(mk(1, FA, 1, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(0, FA, 1, 1, 8'h11, 1, 0, 0, 0));
        tbl.push_back(mk(0, FA, 1, 1, 8'h22, 0, 0, 0, 0));
        tbl.push_back(mk(0, FA, 1, 1, 8'h33, 0, 0, 0, 0));
        tbl.push_back(mk(0, FA, 1, 1, 8'h44, 0, 1, 1, 0));
        tbl.push_back(mk(0, FA, 1, 0, 8'h00, 0, 0, 1, 1));
        // stall on word 2, then on the last word
        tbl.push_back(mk(1, FA, 1, 0, 8'h00, 0, 0, 1, 1));
        tbl.push_back(mk(0, FA, 1, 1, 8'h11, 1, 0, 0, 1));
        tbl.push_back(mk(0, FA, 1, 1, 8'h22, 0, 0, 0, 1));
        tbl.push_back(mk(0, FA, 0, 1, 8'h33, 0, 0, 0, 1));
        tbl.push_back(mk(0, FA, 0, 1, 8'h33, 0, 0, 0, 1));
        tbl.push_back(mk(0, FA, 0, 1, 8'h33, 0, 0, 0, 1));
        tbl.push_back(mk(0, FA, 1, 1, 8'h33, 0, 0, 0, 1));
        tbl.push_back(mk(0, FA, 0, 1, 8'h44, 0, 1, 0, 1));
        tbl.push_back(mk(0, FA, 1, 1, 8'h44, 0, 1, 1, 1));
        // back to back A then B; the counter wraps after B
        tbl.push_back(mk(1, FA, 1, 0, 8'h00, 0, 0, 1, 2));
        tbl.push_back(mk(1, FB, 1, 1, 8'h11, 1, 0, 0, 2));
        tbl.push_back(mk(1, FB, 1, 1, 8'h22, 0, 0, 0, 2));
        tbl.push_back(mk(1, FB, 1, 1, 8'h33, 0, 0, 0, 2));
        tbl.push_back(mk(1, FB, 1, 1, 8'h44, 0, 1, 1, 2));
        tbl.push_back(mk(0, FB, 1, 1, 8'h55, 1, 0, 0, 3));
        tbl.push_back(mk(0, FB, 1, 1, 8'h66, 0, 0, 0, 3));
        tbl.push_back(mk(0, FB, 1, 1, 8'h77, 0, 0, 0, 3));
        tbl.push_back(mk(0, FB, 1, 1, 8'h88, 0, 1, 1, 3));
        // load_data changes while busy; C is taken only at the last beat
        tbl.push_back(mk(1, FA, 1, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(1, FC, 1, 1, 8'h11, 1, 0, 0, 0));
        tbl.push_back(mk(1, FC, 1, 1, 8'h22, 0, 0, 0, 0));
        tbl.push_back(mk(1, FC, 1, 1, 8'h33, 0, 0, 0, 0));
        tbl.push_back(mk(1, FC, 1, 1, 8'h44, 0, 1, 1, 0));
        tbl.push_back(mk(0, FC, 1, 1, 8'hEF, 1, 0, 0, 1));
        tbl.push_back(mk(0, FC, 1, 1, 8'hBE, 0, 0, 0, 1));
        tbl.push_back(mk(0, FC, 1, 1, 8'hAD, 0, 0, 0, 1));
        tbl.push_back(mk(0, FC, 1, 1, 8'hDE, 0, 1, 1, 1));
        tbl.push_back(mk(0, FC, 1, 0, 8'h00, 0, 0, 1, 2));

        foreach (tbl[i]) begin
            load_valid = tbl[i].lv; load_data = tbl[i].ld; ser_ready = tbl[i].sr;
            #1;
            cmp($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ef, tbl[i].el,
                tbl[i].er, tbl[i].ec);
            @(negedge clk);
        end

        // reset in the middle of a frame (counter is 2 at this point)
        load_valid = 1'b1; load_data = FA; ser_ready = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        check("midrst.pre_data", 32'(ser_data), 32'h22);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("midrst%0d.ser_data", k), 32'(ser_data), 32'h0);
            cmp($sformatf("midrst%0d", k), 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        cmp("postrst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0);

        // randomized traffic against the queue model
        exp_q.delete();
        sent_frames = 0;
        for (int c = 0; c < 800; c++) begin
            logic          ev, er, lv, sr, rn;
            logic [31:0]   ld;
            rn = ($urandom_range(0, 99) != 0);
            lv = ($urandom_range(0, 2) != 0);
            sr = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < MW; b++) begin
                ld[b*DW +: DW] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            rst_n = rn; load_valid = lv; load_data = ld; ser_ready = sr;
            #1;
            ev = (exp_q.size() != 0);
            er = (exp_q.size() == 0) || (exp_q.size() == 1 && sr);
            cmp($sformatf("rnd%0d", c), ev, ev ? exp_q[0] : 8'h00,
                exp_q.size() == MW, exp_q.size() == 1, er, CW'(sent_frames % (1 << CW)));
            @(posedge clk);
            if (!rn) begin
                exp_q.delete();
                sent_frames = 0;
            end else begin
                if (ev && sr) begin
                    if (exp_q.size() == 1) sent_frames++;
                    void'(exp_q.pop_front());
                end
                if (lv && er) begin
                    for (int b = 0; b < MW; b++) exp_q.push_back(ld[b*DW +: DW]);
                end
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
